instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Instruction fetch stage of the single-issue MIPS core: holds the program counter, drives the combinational instruction ROM (`rom_using_file`), and registers the returned word into an IF/ID output register toward decode. Supports stall via a valid/ready handshake, branch/jump redirect with flush, and an external halt. The ROM read is combinational, so the fetch latency is one cycle from PC to registered instruction.

## Interface
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset.
- `ADDR_W`, 32: ROM address width. PC, targets and `rom_address` are all this wide.
- `clk`  in  1  system clock, rising-edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `rom_address`  out  32  word index into the ROM, equal to PC[31:2].
- `rom_read_en`  out  1  ROM read enable.
- `rom_ce`  out  1  ROM chip enable.
- `rom_data`  in  32  instruction word from the ROM, valid in the same cycle.
- `redirect`  in  1  branch taken or jump from EX. Single-cycle pulse.
- `redirect_target`  in  32  byte address of the next instruction when `redirect`=1.
- `halt_req`  in  1  level. Stop fetching while high.
- `id_ready`  in  1  decode accepts the IF/ID register this cycle.
- `if_valid`  out  1  IF/ID register holds a valid instruction.
- `if_instr`  out  32  fetched instruction.
- `if_pc`  out  32  byte address of `if_instr`.
- `if_pc_plus4`  out  32  `if_pc`+4, wrapping modulo 2^32.
- `misalign_err`  out  1  sticky flag. Set when a redirect target has [1:0]≠0.
- `halted`  out  1  high while in HALT.

## Operation
- The FSM has four states: BOOT, RUN, STALL and HALT. Reset enters BOOT.
- BOOT to RUN after one cycle. No fetch occurs in BOOT.
- **Advance condition:** `adv` = (state==RUN or STALL) and (!if_valid or id_ready) and !halt_req.
- **Fetch on `adv`:** `if_instr`←`rom_data`, `if_pc`←PC, `if_pc_plus4`←PC+4, `if_valid`←1, PC←PC+4.
- **Handshake:** if `if_valid` and `id_ready`, the output is consumed.
  - If `adv` is also true in that cycle, the register is refilled in the same cycle.
  - If not, `if_valid`←0.
- **Stall:** in RUN, if `if_valid` and !`id_ready`, go to STALL. PC and the IF/ID register are held stable.
  - STALL returns to RUN on `id_ready`.
- **Redirect:** has the highest priority in any state except BOOT.
  - PC←{`redirect_target`[31:2],2'b00} and `if_valid`←0 (flush). No fetch occurs that cycle, so the wrong-path word is dropped.
  - State becomes RUN unless `halt_req` is high, in which case it becomes HALT.
  - If `redirect_target`[1:0]≠0, `misalign_err`←1. It clears only on reset.
- **Halt:** `halt_req` high in RUN or STALL goes to HALT. The IF/ID register is held until consumed (the handshake above still applies).
  - HALT returns to RUN when `halt_req` falls. PC is preserved.
- **ROM control:** `rom_ce`=(state≠BOOT and state≠HALT). `rom_read_en`=`adv` and !`redirect`.
- **Wrap-around:** PC 32'hFFFF_FFFC + 4 = 32'h0000_0000. No flag is raised.

## Timing
- **Reset values:**
  - PC=`RESET_PC`, state=BOOT.
  - `if_valid`=0, `if_instr`=0, `if_pc`=0, `if_pc_plus4`=0.
  - `misalign_err`=0, `halted`=0, `rom_ce`=0, `rom_read_en`=0.
- **Reset mid-operation:** asserting `rst` asynchronously clears everything above. Any in-flight instruction is lost.
- **Latency:** the PC presented in cycle N appears on `if_instr`/`if_pc` after edge N. Throughput is one instruction per cycle while `id_ready`=1.
- The first valid output is at the 2nd rising edge after `rst` deasserts (BOOT, then fetch).
- **Redirect:** the target is on `rom_address` in the cycle after `redirect`. Its instruction is valid one edge later, so the redirect penalty is one bubble.
- **Simultaneous events:**
  - `redirect` together with `id_ready`: the flush wins and the old `if_valid` output is still considered consumed.
  - `redirect` together with `halt_req`: PC is updated, then HALT.
- **Outputs:** all are registered except `rom_address`, `rom_read_en` and `rom_ce`, which are combinational from state, PC and inputs.

## Structure
- Shared package `mips_pkg` holds:
  - the state encoding (2 bits: BOOT=0, RUN=1, STALL=2, HALT=3);
  - `RESET_PC_DEFAULT`;
  - `INSTR_W`=32;
  - NOP word 32'h0000_0000.
- Sub-module `pc_next_mux` is combinational. Its inputs are PC, `adv`, `redirect` and `redirect_target`; its outputs are next PC and the misalign bit.
- The FSM and the IF/ID register live in the top module.

## Test plan
- **Reset/boot:** preload ROM[0..3]=A0..A3 and hold `id_ready`=1. After `rst` deasserts, expect `if_instr`=A0 with `if_pc`=0 at edge 2, then A1 with `if_pc`=4 and A2 with `if_pc`=8 on consecutive edges.
- **Stall:** drop `id_ready` for 3 cycles while `if_instr`=A1. Expect `if_instr`/`if_pc` held at A1/4, PC stable and `rom_read_en`=0. After release, expect A2 on the next edge.
- **Redirect:** pulse `redirect` with target 32'h40 while `if_valid`=1. Expect `if_valid`=0 for one cycle, then `if_instr`=ROM[16] with `if_pc`=32'h40, and no wrong-path word delivered.
- **Misaligned redirect:** target 32'h42. Expect PC=32'h40 and `misalign_err`=1 until the next `rst`.
- **Halt:** assert `halt_req` for 4 cycles. Expect `halted`=1 and `rom_ce`=0 with PC unchanged. After deassert, fetch resumes at the next sequential PC.
- **Wrap/simultaneous events:**
  - With PC=32'hFFFF_FFFC, expect `if_pc_plus4`=0 and next `if_pc`=0.
  - With `redirect` and `halt_req` in the same cycle, expect PC=target and state HALT.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS front end: fetch FSM encoding, reset PC and
// instruction word constants.
package mips_pkg;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2,
        ST_HALT  = 2'd3
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int          INSTR_W          = 32;
    localparam logic [INSTR_W-1:0] NOP_WORD  = 32'h0000_0000;

endpackage

// File: rtl/pc_next_mux.sv
// Next-PC selection: a redirect forces a word-aligned target, otherwise PC
// steps by one word whenever the fetch stage advances.
module pc_next_mux
    import mips_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic              adv,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_target,
    output logic [ADDR_W-1:0] pc_next,
    output logic              misalign
);

    always_comb begin
        pc_next = pc;
        if (redirect) begin
            pc_next = {redirect_target[ADDR_W-1:2], 2'b00};
        end else if (adv) begin
            pc_next = pc + ADDR_W'(4);
        end
    end

    assign misalign = redirect & (redirect_target[1:0] != 2'b00);

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC, combinational ROM access and the IF/ID register
// with valid/ready handshake, redirect flush and external halt.
//
//   state | meaning
//   BOOT  | one idle cycle after reset, no fetch
//   RUN   | fetching, one word per cycle while decode accepts
//   STALL | IF/ID full and decode not ready, PC and IF/ID held
//   HALT  | halt_req high, ROM disabled, PC preserved
module instr_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          ADDR_W   = 32
) (
    input  logic                clk,
    input  logic                rst,
    output logic [ADDR_W-1:0]   rom_address,
    output logic                rom_read_en,
    output logic                rom_ce,
    input  logic [INSTR_W-1:0]  rom_data,
    input  logic                redirect,
    input  logic [ADDR_W-1:0]   redirect_target,
    input  logic                halt_req,
    input  logic                id_ready,
    output logic                if_valid,
    output logic [INSTR_W-1:0]  if_instr,
    output logic [ADDR_W-1:0]   if_pc,
    output logic [ADDR_W-1:0]   if_pc_plus4,
    output logic                misalign_err,
    output logic                halted
);

    fetch_state_t      state, state_next;
    logic [ADDR_W-1:0] pc, pc_next;
    logic              adv;
    logic              redir_eff;
    logic              misalign_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_BOOT;
            pc     <= ADDR_W'(RESET_PC);
            halted <= 1'b0;
        end else begin
            state  <= state_next;
            pc     <= pc_next;
            halted <= (state_next == ST_HALT);
        end
    end

    always_comb begin
        state_next  = state;
        adv         = 1'b0;
        redir_eff   = 1'b0;
        rom_ce      = 1'b0;
        rom_read_en = 1'b0;

        if (state != ST_BOOT) begin
            redir_eff = redirect;
        end
        if ((state == ST_RUN) || (state == ST_STALL)) begin
            adv = (!if_valid || id_ready) && !halt_req;
        end
        rom_ce      = (state != ST_BOOT) && (state != ST_HALT);
        rom_read_en = adv && !redirect;

        case (state)
            ST_BOOT:  state_next = ST_RUN;
            ST_RUN: begin
                if (halt_req) begin
                    state_next = ST_HALT;
                end else if (if_valid && !id_ready) begin
                    state_next = ST_STALL;
                end
            end
            ST_STALL: begin
                if (halt_req) begin
                    state_next = ST_HALT;
                end else if (id_ready) begin
                    state_next = ST_RUN;
                end
            end
            ST_HALT: begin
                if (!halt_req) begin
                    state_next = ST_RUN;
                end
            end
        endcase

        // Redirect overrides every non-boot transition; halt still wins the destination.
        if (redir_eff) begin
            state_next = halt_req ? ST_HALT : ST_RUN;
        end
    end

    pc_next_mux #(
        .ADDR_W(ADDR_W)
    ) u_pc_next_mux (
        .pc              (pc),
        .adv             (adv),
        .redirect        (redir_eff),
        .redirect_target (redirect_target),
        .pc_next         (pc_next),
        .misalign        (misalign_hit)
    );

    assign rom_address = {2'b00, pc[ADDR_W-1:2]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_valid     <= 1'b0;
            if_instr     <= NOP_WORD;
            if_pc        <= '0;
            if_pc_plus4  <= '0;
            misalign_err <= 1'b0;
        end else begin
            if (misalign_hit) begin
                misalign_err <= 1'b1;
            end
            // Flush drops both the current word and the wrong-path ROM word.
            if (redir_eff) begin
                if_valid <= 1'b0;
            end else if (adv) begin
                if_valid    <= 1'b1;
                if_instr    <= rom_data;
                if_pc       <= pc;
                if_pc_plus4 <= pc + ADDR_W'(4);
            end else if (if_valid && id_ready) begin
                if_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: directed boot/stall/redirect/halt/wrap checks
// plus randomized traffic compared each cycle against a behavioural model.
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst;
    logic [31:0] rom_address;
    logic        rom_read_en;
    logic        rom_ce;
    logic [31:0] rom_data;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        halt_req;
    logic        id_ready;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
    logic        misalign_err;
    logic        halted;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_on   = 0;

    instr_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .ADDR_W   (32)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .rom_address     (rom_address),
        .rom_read_en     (rom_read_en),
        .rom_ce          (rom_ce),
        .rom_data        (rom_data),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .halt_req        (halt_req),
        .id_ready        (id_ready),
        .if_valid        (if_valid),
        .if_instr        (if_instr),
        .if_pc           (if_pc),
        .if_pc_plus4     (if_pc_plus4),
        .misalign_err    (misalign_err),
        .halted          (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM contents: words 0..3 are A0..A3, everything else a scrambled index.
    function automatic logic [31:0] rom_word(input logic [31:0] idx);
        if (idx < 32'd4) return 32'hA0A0_0000 + idx;
        return (idx * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    assign rom_data = rom_word(rom_address);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: only three phases matter to the outside (booting,
    // active, halted); a stalled stage looks exactly like an active one.
    logic [31:0] m_pc, m_instr, m_ipc, m_ipc4;
    bit          m_v, m_err, m_boot, m_halt;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pc   <= 32'h0;
            m_instr <= 32'h0;
            m_ipc  <= 32'h0;
            m_ipc4 <= 32'h0;
            m_v    <= 1'b0;
            m_err  <= 1'b0;
            m_boot <= 1'b1;
            m_halt <= 1'b0;
        end else if (m_boot) begin
            m_boot <= 1'b0;
        end else begin
            if (redirect) begin
                m_v  <= 1'b0;
                m_pc <= redirect_target & 32'hFFFF_FFFC;
                if ((redirect_target % 4) != 0) m_err <= 1'b1;
            end else if (!m_halt && (!m_v || id_ready) && !halt_req) begin
                m_instr <= rom_word(m_pc / 4);
                m_ipc   <= m_pc;
                m_ipc4  <= m_pc + 32'd4;
                m_v     <= 1'b1;
                m_pc    <= m_pc + 32'd4;
            end else if (m_v && id_ready) begin
                m_v <= 1'b0;
            end
            m_halt <= halt_req;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            automatic bit take = !m_boot && !m_halt && (!m_v || id_ready) && !halt_req;
            check("if_valid", 32'(if_valid), 32'(m_v));
            if (m_v) begin
                check("if_instr", if_instr, m_instr);
                check("if_pc", if_pc, m_ipc);
                check("if_pc_plus4", if_pc_plus4, m_ipc4);
            end
            check("misalign_err", 32'(misalign_err), 32'(m_err));
            check("halted", 32'(halted), 32'(m_halt));
            check("rom_ce", 32'(rom_ce), 32'(!m_boot && !m_halt));
            check("rom_read_en", 32'(rom_read_en), 32'(take && !redirect));
            check("rom_address", rom_address, m_pc >> 2);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        id_ready = 1'b1;
        redirect = 1'b0;
        halt_req = 1'b0;
        redirect_target = 32'h0;

        tick();
        chk_on = 1'b1;
        check("rst_if_valid", 32'(if_valid), 32'h0);
        check("rst_if_pc", if_pc, 32'h0);
        tick();
        #1 rst = 1'b0;

        tick();
        check("boot_no_fetch", 32'(if_valid), 32'h0);
        tick();
        check("first_instr", if_instr, 32'hA0A0_0000);
        check("first_pc", if_pc, 32'h0);
        check("first_pc4", if_pc_plus4, 32'h4);
        tick();
        check("second_instr", if_instr, 32'hA0A0_0001);
        check("second_pc", if_pc, 32'h4);
        #1 id_ready = 1'b0;

        repeat (3) begin
            tick();
            check("stall_instr", if_instr, 32'hA0A0_0001);
            check("stall_pc", if_pc, 32'h4);
            check("stall_rom_addr", rom_address, 32'h2);
            check("stall_read_en", 32'(rom_read_en), 32'h0);
        end
        #1 id_ready = 1'b1;

        tick();
        check("after_stall_instr", if_instr, 32'hA0A0_0002);
        check("after_stall_pc", if_pc, 32'h8);
        #1 begin redirect = 1'b1; redirect_target = 32'h40; end

        tick();
        check("redirect_flush", 32'(if_valid), 32'h0);
        check("redirect_rom_addr", rom_address, 32'h10);
        #1 redirect = 1'b0;
        tick();
        check("redirect_valid", 32'(if_valid), 32'h1);
        check("redirect_pc", if_pc, 32'h40);
        check("redirect_instr", if_instr, rom_word(32'h10));
        #1 begin redirect = 1'b1; redirect_target = 32'h42; end

        tick();
        check("misalign_set", 32'(misalign_err), 32'h1);
        check("misalign_rom_addr", rom_address, 32'h10);
        #1 redirect = 1'b0;
        tick();
        check("misalign_pc", if_pc, 32'h40);
        #1 halt_req = 1'b1;

        repeat (4) begin
            tick();
            check("halt_halted", 32'(halted), 32'h1);
            check("halt_rom_ce", 32'(rom_ce), 32'h0);
            check("halt_rom_addr", rom_address, 32'h11);
        end
        #1 halt_req = 1'b0;
        tick();
        check("unhalt_halted", 32'(halted), 32'h0);
        tick();
        check("resume_pc", if_pc, 32'h44);
        check("resume_instr", if_instr, rom_word(32'h11));
        #1 begin redirect = 1'b1; redirect_target = 32'hFFFF_FFFC; end

        tick();
        #1 redirect = 1'b0;
        tick();
        check("wrap_pc", if_pc, 32'hFFFF_FFFC);
        check("wrap_pc4", if_pc_plus4, 32'h0);
        tick();
        check("wrap_next_pc", if_pc, 32'h0);
        check("wrap_next_instr", if_instr, 32'hA0A0_0000);
        #1 begin redirect = 1'b1; redirect_target = 32'h80; halt_req = 1'b1; end

        tick();
        check("redir_halt_halted", 32'(halted), 32'h1);
        check("redir_halt_addr", rom_address, 32'h20);
        #1 redirect = 1'b0;
        tick();
        check("redir_halt_hold", rom_address, 32'h20);
        #1 halt_req = 1'b0;
        tick();
        tick();
        check("redir_halt_resume", if_pc, 32'h80);
        check("misalign_sticky", 32'(misalign_err), 32'h1);

        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #2;
            rst      = 1'b0;
            id_ready = ($urandom_range(0, 3) != 0);
            redirect = ($urandom_range(0, 9) == 0);
            case ($urandom_range(0, 3))
                0: redirect_target = $urandom();
                1: redirect_target = 32'hFFFF_FFF0 | ($urandom() & 32'hF);
                default: redirect_target = $urandom() & 32'hFC;
            endcase
            if ($urandom_range(0, 7) == 0) halt_req = ~halt_req;
            if (i == 1500) begin
                #1 rst = 1'b1;
            end
        end

        @(posedge clk);
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
